// File: rtl/cls_serial_sub_seq_pkg.sv
// Shared definitions for the serial multi-word subtract sequencer:
// slice width and FSM state encoding.
package cls_serial_sub_seq_pkg;

    localparam int unsigned CLS_SLICE_W = 16;

    // 2'd3 is unused and recovers to S_IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cls_serial_sub_seq_cls16.sv
// 16-bit lookahead subtract slice: d = x - y - bin, with group borrow
// generate (GG) and propagate (GP) for chaining slices.
module cls_serial_sub_seq_cls16
    import cls_serial_sub_seq_pkg::*;
(
    input  logic [CLS_SLICE_W-1:0] x,
    input  logic [CLS_SLICE_W-1:0] y,
    input  logic                   bin,
    output logic [CLS_SLICE_W-1:0] d,
    output logic                   GP,
    output logic                   GG
);

    logic [CLS_SLICE_W-1:0] g;
    logic [CLS_SLICE_W-1:0] p;
    logic                   b;
    logic                   gg_acc;
    logic                   gp_acc;

    // bit generates a borrow when x=0,y=1; passes an incoming borrow when x==y
    always_comb begin
        g      = ~x & y;
        p      = ~(x ^ y);
        d      = '0;
        b      = bin;
        gg_acc = 1'b0;
        gp_acc = 1'b1;
        for (int i = 0; i < int'(CLS_SLICE_W); i++) begin
            d[i]   = x[i] ^ y[i] ^ b;
            b      = g[i] | (p[i] & b);
            gg_acc = g[i] | (p[i] & gg_acc);
            gp_acc = gp_acc & p[i];
        end
        GG = gg_acc;
        GP = gp_acc;
    end

endmodule

// File: rtl/cls_serial_sub_seq.sv
// Multi-word subtractor D = X - Y - BIN computed one 16-bit slice per clock,
// LSB first, through a single shared lookahead slice with a registered borrow.
module cls_serial_sub_seq
    import cls_serial_sub_seq_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CLS_SLICE_W*WORDS-1:0] x,
    input  logic [CLS_SLICE_W*WORDS-1:0] y,
    input  logic                         bin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CLS_SLICE_W*WORDS-1:0] d,
    output logic                         bout,
    output logic                         ovf,
    output logic                         zero
);

    localparam int unsigned W     = CLS_SLICE_W * WORDS;
    localparam int unsigned IDX_W = $clog2(WORDS);

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       idx;
    logic                   brw;
    logic [W-1:0]           opx;
    logic [W-1:0]           opy;
    logic [CLS_SLICE_W-1:0] sx;
    logic [CLS_SLICE_W-1:0] sy;
    logic [CLS_SLICE_W-1:0] sd;
    logic                   sgp;
    logic                   sgg;
    logic                   brw_new;
    logic                   last;
    logic [W-1:0]           d_wr;

    assign last    = (idx == IDX_W'(WORDS - 1));
    assign brw_new = sgg | (sgp & brw);

    // slice operand mux and result write-back view selected by idx
    always_comb begin
        sx   = '0;
        sy   = '0;
        d_wr = d;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (idx == IDX_W'(i)) begin
                sx = opx[i*CLS_SLICE_W +: CLS_SLICE_W];
                sy = opy[i*CLS_SLICE_W +: CLS_SLICE_W];
                d_wr[i*CLS_SLICE_W +: CLS_SLICE_W] = sd;
            end
        end
    end

    cls_serial_sub_seq_cls16 u_slice (
        .x   (sx),
        .y   (sy),
        .bin (brw),
        .d   (sd),
        .GP  (sgp),
        .GG  (sgg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid && in_ready) state_next = S_RUN;
            S_RUN:   if (last)                 state_next = S_DONE;
            S_DONE:  if (out_ready)            state_next = S_IDLE;
            default:                           state_next = S_IDLE;
        endcase
    end

    // handshake flags track the next state so they are registered yet exact
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next == S_IDLE);
            out_valid <= (state_next == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opx  <= '0;
            opy  <= '0;
            brw  <= 1'b0;
            idx  <= '0;
            d    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        opx <= x;
                        opy <= y;
                        brw <= bin;
                        idx <= '0;
                    end
                end
                S_RUN: begin
                    d   <= d_wr;
                    brw <= brw_new;
                    if (last) begin
                        bout <= brw_new;
                        ovf  <= (opx[W-1] != opy[W-1]) && (d_wr[W-1] != opx[W-1]);
                        zero <= (d_wr == '0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
